tail_light_ctrl: RTL and testbench
==================================

// Module: tail_light_ctrl
// PURPOSE
//  Turn-signal/brake controller driving two 3-lamp tail-light banks (left, right).
//  Arbitrates driver requests (left, right, hazard, brake) and sequences each bank
//  through the 001->011->111->000 sweep at a slow, prescaled tick rate.
//  Sits between the switch/debounce inputs and the lamp drivers.
// PARAMETERS
//  TICK_DIV  default 5_000_000  clk cycles per sequencer step; legal range >= 2
// PORTS
//  clk      in   1  system clock
//  reset    in   1  synchronous, active-high reset
//  left     in   1  left-turn request (level)
//  right    in   1  right-turn request (level)
//  hazard   in   1  hazard request (level)
//  brake    in   1  brake pedal (level)
//  light_l  out  3  left bank lamps, bit0 = innermost
//  light_r  out  3  right bank lamps, bit0 = innermost
//  active   out  1  high while sequencer is not IDLE
// BEHAVIOUR
//  Clocking: one clock; reset is synchronous and active-high.
//  Reset: step counter = 0, state = IDLE, light_l = light_r = 3'b000, active = 0.
//   Reset wins over every other input; asserting it mid-sequence returns to IDLE
//   and clears the lamps on the next edge.
//  Tick: counter 0..TICK_DIV-1 wraps to 0; tick = 1 for one clk when count == TICK_DIV-1.
//   Counter width = $clog2(TICK_DIV). Counter free-runs; it does not resync to requests.
//  States: IDLE, L1, L2, L3, R1, R2, R3, HAZ_ON, HAZ_OFF. The state changes only on a
//   clock edge where tick = 1; otherwise it holds.
//  Decision rule, applied in IDLE and HAZ_OFF (priority order):
//   1. hazard | (left & right) -> HAZ_ON
//   2. left                    -> L1
//   3. right                   -> R1
//   4. otherwise               -> IDLE
//  Turn sweep: L1 -> L2 -> L3 -> IDLE (R likewise).
//   Dropping left/right mid-sweep does not abort the sweep; it completes to IDLE.
//  Preemption: hazard sampled high on a tick in any L*/R* state -> HAZ_ON.
//   A request on the opposite side mid-sweep is ignored until IDLE.
//  Hazard: HAZ_ON -> HAZ_OFF, unconditionally.
//  Pattern per state (turning bank):
//   L1/R1 = 001, L2/R2 = 011, L3/R3 = 111.
//   HAZ_ON = 111 on both banks; HAZ_OFF and IDLE = 000.
//  Brake overlay: a bank not owned by a turn sweep shows 111 while brake = 1.
//   During L*, light_r = brake ? 111 : 000 (mirror for R*).
//   Brake is ignored in HAZ_ON/HAZ_OFF.
//  Output timing: light_l, light_r and active are registered from next-state and brake.
//   They update on the same edge as the state (tick edge).
//   A brake change appears on the lamps 1 clk later, regardless of tick.
//  active = 1 in every state except IDLE.
// STRUCTURE
//  tail_light_pkg holds:
//   - state enum tl_state_e (4-bit encoding)
//   - constants LAMP_OFF=3'b000, LAMP_1=3'b001, LAMP_2=3'b011, LAMP_ALL=3'b111
//  Sub-module tail_light_tick (params TICK_DIV; ports clk, reset, tick) holds the prescaler.
//  The FSM and output registers stay in tail_light_ctrl.
// TESTING (bench uses TICK_DIV = 4)
//  1. Reset held 3 clk, then released, no requests -> lamps 000, active 0 for 20 clk.
//  2. left=1 held -> at successive ticks light_l = 001, 011, 111, 000, then 001...;
//     light_r = 000 throughout.
//  3. left pulsed high for one tick, then low -> full sweep 001, 011, 111, 000,
//     then stays 000 (IDLE).
//  4. right sweep at R2, hazard raised -> next tick both banks 111, then 000,
//     alternating while hazard = 1; brake toggling has no effect.
//  5. left & right both = 1 from IDLE -> hazard pattern on both banks.
//  6. brake = 1 with left sweep running -> light_r = 111 one clk after brake rises,
//     light_l keeps sweeping; reset asserted at L2 -> both 000, active 0 next edge.

Source files
------------

// File: rtl/tail_light_pkg.sv
// rtl/tail_light_pkg.sv - shared states, lamp patterns and pattern helper for the tail-light controller
package tail_light_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_L1      = 4'd1,
        ST_L2      = 4'd2,
        ST_L3      = 4'd3,
        ST_R1      = 4'd4,
        ST_R2      = 4'd5,
        ST_R3      = 4'd6,
        ST_HAZ_ON  = 4'd7,
        ST_HAZ_OFF = 4'd8
    } tl_state_e;

    localparam logic [2:0] LAMP_OFF = 3'b000;
    localparam logic [2:0] LAMP_1   = 3'b001;
    localparam logic [2:0] LAMP_2   = 3'b011;
    localparam logic [2:0] LAMP_ALL = 3'b111;

    // Sweep pattern shown by the bank that owns a turn state.
    function automatic logic [2:0] sweep_lamp(input tl_state_e st);
        logic [2:0] lamp;
        lamp = LAMP_OFF;
        case (st)
            ST_L1, ST_R1: lamp = LAMP_1;
            ST_L2, ST_R2: lamp = LAMP_2;
            ST_L3, ST_R3: lamp = LAMP_ALL;
            default:      lamp = LAMP_OFF;
        endcase
        return lamp;
    endfunction

endpackage

// File: rtl/tail_light_tick.sv
// rtl/tail_light_tick.sv - free-running prescaler producing a one-clock tick every TICK_DIV clocks
module tail_light_tick #(
    parameter int TICK_DIV = 5_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/tail_light_ctrl.sv
// rtl/tail_light_ctrl.sv - turn/hazard/brake arbiter and lamp sequencer for two 3-lamp tail-light banks
module tail_light_ctrl
    import tail_light_pkg::*;
#(
    parameter int TICK_DIV = 5_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       left,
    input  logic       right,
    input  logic       hazard,
    input  logic       brake,
    output logic [2:0] light_l,
    output logic [2:0] light_r,
    output logic       active
);

    logic      tick;
    tl_state_e state;
    tl_state_e state_next;
    tl_state_e decided;
    logic [2:0] light_l_next;
    logic [2:0] light_r_next;

    tail_light_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            light_l <= LAMP_OFF;
            light_r <= LAMP_OFF;
            active  <= 1'b0;
        end else begin
            state   <= state_next;
            light_l <= light_l_next;
            light_r <= light_r_next;
            active  <= (state_next != ST_IDLE);
        end
    end

    // Arbitration from a resting state; both turn switches together count as hazard.
    always_comb begin
        decided = ST_IDLE;
        if (hazard || (left && right)) begin
            decided = ST_HAZ_ON;
        end else if (left) begin
            decided = ST_L1;
        end else if (right) begin
            decided = ST_R1;
        end
    end

    always_comb begin
        state_next = state;
        if (tick) begin
            case (state)
                ST_IDLE, ST_HAZ_OFF: state_next = decided;
                ST_L1:      state_next = hazard ? ST_HAZ_ON : ST_L2;
                ST_L2:      state_next = hazard ? ST_HAZ_ON : ST_L3;
                ST_L3:      state_next = hazard ? ST_HAZ_ON : ST_IDLE;
                ST_R1:      state_next = hazard ? ST_HAZ_ON : ST_R2;
                ST_R2:      state_next = hazard ? ST_HAZ_ON : ST_R3;
                ST_R3:      state_next = hazard ? ST_HAZ_ON : ST_IDLE;
                ST_HAZ_ON:  state_next = ST_HAZ_OFF;
                default:    state_next = ST_IDLE;
            endcase
        end
    end

    // Lamps follow the upcoming state so they move on the same edge as the FSM.
    always_comb begin
        light_l_next = brake ? LAMP_ALL : LAMP_OFF;
        light_r_next = brake ? LAMP_ALL : LAMP_OFF;
        case (state_next)
            ST_L1, ST_L2, ST_L3: light_l_next = sweep_lamp(state_next);
            ST_R1, ST_R2, ST_R3: light_r_next = sweep_lamp(state_next);
            ST_HAZ_ON: begin
                light_l_next = LAMP_ALL;
                light_r_next = LAMP_ALL;
            end
            ST_HAZ_OFF: begin
                light_l_next = LAMP_OFF;
                light_r_next = LAMP_OFF;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tail_light_ctrl.sv
// tb/tb_tail_light_ctrl.sv - directed vector bench for tail_light_ctrl with TICK_DIV = 4
module tb_tail_light_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       left = 1'b0;
    logic       right = 1'b0;
    logic       hazard = 1'b0;
    logic       brake = 1'b0;
    logic [2:0] light_l;
    logic [2:0] light_r;
    logic       active;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic       l;
        logic       r;
        logic       h;
        logic       b;
        logic [2:0] exp_l;
        logic [2:0] exp_r;
        logic       exp_a;
    } vec_t;

    vec_t vecs[$];

    tail_light_ctrl #(.TICK_DIV(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .left    (left),
        .right   (right),
        .hazard  (hazard),
        .brake   (brake),
        .light_l (light_l),
        .light_r (light_r),
        .active  (active)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [2:0] el, input logic [2:0] er, input logic ea);
        checks++;
        if (light_l !== el || light_r !== er || active !== ea) begin
            failures++;
            $display("FAIL %s: got l=%b r=%b active=%b, want l=%b r=%b active=%b",
                     name, light_l, light_r, active, el, er, ea);
        end
    endtask

    task automatic add(input logic l, input logic r, input logic h, input logic b,
                       input logic [2:0] el, input logic [2:0] er, input logic ea);
        vec_t v;
        v.l = l; v.r = r; v.h = h; v.b = b;
        v.exp_l = el; v.exp_r = er; v.exp_a = ea;
        vecs.push_back(v);
    endtask

    initial begin
        // Each vector: apply inputs, advance exactly one tick period, compare.
        // left held: sweep and restart
        add(1,0,0,0, 3'b001, 3'b000, 1);
        add(1,0,0,0, 3'b011, 3'b000, 1);
        add(1,0,0,0, 3'b111, 3'b000, 1);
        add(1,0,0,0, 3'b000, 3'b000, 0);
        add(1,0,0,0, 3'b001, 3'b000, 1);
        // left dropped mid-sweep completes
        add(0,0,0,0, 3'b011, 3'b000, 1);
        add(0,0,0,0, 3'b111, 3'b000, 1);
        add(0,0,0,0, 3'b000, 3'b000, 0);
        add(0,0,0,0, 3'b000, 3'b000, 0);
        // single-tick left pulse
        add(1,0,0,0, 3'b001, 3'b000, 1);
        add(0,0,0,0, 3'b011, 3'b000, 1);
        add(0,0,0,0, 3'b111, 3'b000, 1);
        add(0,0,0,0, 3'b000, 3'b000, 0);
        add(0,0,0,0, 3'b000, 3'b000, 0);
        // right sweep preempted by hazard at R2, brake ignored
        add(0,1,0,0, 3'b000, 3'b001, 1);
        add(0,1,0,0, 3'b000, 3'b011, 1);
        add(0,1,1,0, 3'b111, 3'b111, 1);
        add(0,1,1,1, 3'b000, 3'b000, 1);
        add(0,1,1,0, 3'b111, 3'b111, 1);
        add(0,1,1,1, 3'b000, 3'b000, 1);
        add(0,0,0,0, 3'b000, 3'b000, 0);
        // both turn switches act as hazard
        add(1,1,0,0, 3'b111, 3'b111, 1);
        add(1,1,0,0, 3'b000, 3'b000, 1);
        add(0,0,0,0, 3'b000, 3'b000, 0);
        // opposite side ignored mid-sweep, L3 returns to IDLE not R1
        add(1,0,0,0, 3'b001, 3'b000, 1);
        add(0,1,0,0, 3'b011, 3'b000, 1);
        add(0,1,0,0, 3'b111, 3'b000, 1);
        add(0,1,0,0, 3'b000, 3'b000, 0);
        add(0,0,0,0, 3'b000, 3'b000, 0);
        // brake in IDLE lights both banks
        add(0,0,0,1, 3'b111, 3'b111, 0);
        add(0,0,0,0, 3'b000, 3'b000, 0);

        reset = 1'b1;
        step(3);
        reset = 1'b0;
        check("reset_state", 3'b000, 3'b000, 1'b0);

        for (int i = 0; i < 20; i++) begin
            step(1);
            check($sformatf("idle_cycle_%0d", i), 3'b000, 3'b000, 1'b0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            left   = vecs[i].l;
            right  = vecs[i].r;
            hazard = vecs[i].h;
            brake  = vecs[i].b;
            step(4);
            check($sformatf("vec_%0d", i), vecs[i].exp_l, vecs[i].exp_r, vecs[i].exp_a);
        end

        // brake mid left sweep shows one clock later, between ticks
        left = 1'b1;
        step(4);
        check("brake_seq_l1", 3'b001, 3'b000, 1'b1);
        brake = 1'b1;
        step(1);
        check("brake_one_clk", 3'b001, 3'b111, 1'b1);
        step(3);
        check("brake_seq_l2", 3'b011, 3'b111, 1'b1);

        // reset at L2 wins over brake and left
        reset = 1'b1;
        step(1);
        check("reset_mid_sweep", 3'b000, 3'b000, 1'b0);
        left  = 1'b0;
        brake = 1'b0;
        step(1);
        reset = 1'b0;

        // prescaler restarts from zero after reset: first tick is 4 clocks later
        left = 1'b1;
        step(3);
        check("post_reset_no_tick", 3'b000, 3'b000, 1'b0);
        step(1);
        check("post_reset_first_tick", 3'b001, 3'b000, 1'b1);
        left = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
